// File: rtl/prng_pkg.sv
// Shared constants and helpers for the xorshift generator bank.
// Holds shift triples, the per-channel seed offset and the FSM state type.
package prng_pkg;
   localparam int XS32_A = 13;
   localparam int XS32_B = 17;
   localparam int XS32_C = 5;
   localparam int XS64_A = 13;
   localparam int XS64_B = 7;
   localparam int XS64_C = 17;

   localparam logic [31:0] GOLDEN_OFFSET      = 32'h9E37_79B9;
   localparam logic [63:0] ZERO_SEED_FALLBACK = 64'h1;

   typedef enum logic {S_WARM, S_RUN} prng_state_e;

   // Reset/default seed of a channel; an all-zero state would lock xorshift at zero.
   function automatic logic [63:0] chan_seed(input logic [63:0] base, input int width,
                                             input int chan);
      logic [63:0] mask;
      logic [63:0] v;
      mask = (width == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      v    = (base ^ (64'(chan) * {32'h0, GOLDEN_OFFSET})) & mask;
      if (v == 64'h0) v = ZERO_SEED_FALLBACK;
      return v;
   endfunction
endpackage

// File: rtl/xorshift_step.sv
// One combinational xorshift step s -> s', shift triple chosen by WIDTH.
module xorshift_step
   import prng_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_s,
   output logic [WIDTH-1:0] o_s
);
   localparam int A = (WIDTH == 64) ? XS64_A : XS32_A;
   localparam int B = (WIDTH == 64) ? XS64_B : XS32_B;
   localparam int C = (WIDTH == 64) ? XS64_C : XS32_C;

   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;

   assign w_a = i_s ^ (i_s << A);
   assign w_b = w_a ^ (w_a >> B);
   assign o_s = w_b ^ (w_b << C);
endmodule

// File: rtl/xorshift_prng_bank.sv
// Multi-channel xorshift bank with seed loading and a valid/ready stream.
// Optional warm-up phase after reset/seed is enabled by XORSHIFT_WARMUP_EN.
module xorshift_prng_bank
   import prng_pkg::*;
#(
   parameter int          WIDTH        = 32,
   parameter int          CHANNELS     = 4,
   parameter logic [63:0] DEFAULT_SEED = 64'h1A2B3C4D_5EED5EED,
   parameter int          WARMUP       = 16,
   localparam int         CW           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      seed_valid,
   input  logic [CW-1:0]             seed_chan,
   input  logic [WIDTH-1:0]          seed_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH*CHANNELS-1:0] out_data
);
   logic [CHANNELS-1:0][WIDTH-1:0] w_state;
   logic [CHANNELS-1:0][WIDTH-1:0] w_next;
   logic                           w_fire;
   logic                           w_step;
   logic                           w_seed_any;

   assign w_fire     = out_valid & out_ready;
   assign w_seed_any = seed_valid && (32'(seed_chan) < CHANNELS);
   assign out_data   = w_state;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      localparam logic [WIDTH-1:0] RST_SEED = WIDTH'(chan_seed(DEFAULT_SEED, WIDTH, i));
      logic [WIDTH-1:0] r_s;
      logic             w_hit;

      // A seed beats a same-cycle step on its own channel only.
      assign w_hit      = seed_valid && (seed_chan == CW'(i));
      assign w_state[i] = r_s;

      xorshift_step #(.WIDTH(WIDTH)) u_step (.i_s(r_s), .o_s(w_next[i]));

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n)    r_s <= RST_SEED;
         else if (w_hit)  r_s <= (seed_data == '0) ? RST_SEED : seed_data;
         else if (w_step) r_s <= w_next[i];
      end
   end

`ifdef XORSHIFT_WARMUP_EN
   prng_state_e r_fsm;
   prng_state_e w_fsm_nxt;
   logic [7:0]  r_cnt;
   logic [7:0]  w_cnt_nxt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_fsm <= S_WARM;
         r_cnt <= 8'h0;
      end else begin
         r_fsm <= w_fsm_nxt;
         r_cnt <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_fsm_nxt = r_fsm;
      w_cnt_nxt = r_cnt;
      if (w_seed_any) begin
         w_fsm_nxt = S_WARM;
         w_cnt_nxt = 8'h0;
      end else if (r_fsm == S_WARM) begin
         if (r_cnt == 8'(WARMUP - 1)) begin
            w_fsm_nxt = S_RUN;
            w_cnt_nxt = 8'h0;
         end else begin
            w_cnt_nxt = r_cnt + 8'h1;
         end
      end
   end

   assign w_step    = (r_fsm == S_WARM) | w_fire;
   assign out_valid = (r_fsm == S_RUN);
`else
   logic r_valid;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_valid <= 1'b0;
      else          r_valid <= 1'b1;
   end

   assign w_step    = w_fire;
   assign out_valid = r_valid;
`endif
endmodule

// File: tb/tb_xorshift_prng_bank.sv
// Scoreboard bench for xorshift_prng_bank (WIDTH=32, CHANNELS=4).
module tb_xorshift_prng_bank;
   localparam int          W  = 32;
   localparam int          CH = 4;
   localparam logic [63:0] DS = 64'h1A2B3C4D_5EED5EED;
   localparam int          WU = 16;

   logic           clk        = 1'b0;
   logic           reset_n    = 1'b0;
   logic           seed_valid = 1'b0;
   logic [1:0]     seed_chan  = 2'd0;
   logic [W-1:0]   seed_data  = '0;
   logic           out_valid;
   logic           out_ready  = 1'b0;
   logic [W*CH-1:0] out_data;

   always #5 clk = ~clk;

   xorshift_prng_bank #(.WIDTH(W), .CHANNELS(CH), .DEFAULT_SEED(DS), .WARMUP(WU)) dut (
      .clk(clk), .reset_n(reset_n), .seed_valid(seed_valid), .seed_chan(seed_chan),
      .seed_data(seed_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
   );

   typedef struct packed { logic v; logic [W*CH-1:0] d; } exp_t;
   exp_t sb[$];

   logic [W-1:0] m[CH];
   logic         mv;
   logic         mwarm;
   int           mcnt;
   int           nvec = 0;
   int           nerr = 0;

   function automatic logic [31:0] xs(input logic [31:0] s);
      logic [31:0] a, b;
      a = s ^ (s << 13);
      b = a ^ (a >> 17);
      return b ^ (b << 5);
   endfunction

   function automatic logic [31:0] rseed(input int i);
      logic [31:0] base, v;
      base = DS[31:0];
      v    = base ^ 32'(i * 32'h9E3779B9);
      return (v == 32'h0) ? 32'h1 : v;
   endfunction

   function automatic logic [W*CH-1:0] mpack();
      return {m[3], m[2], m[1], m[0]};
   endfunction

   task automatic chk(input string tag, input logic [W*CH-1:0] obs, input logic [W*CH-1:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < CH; i++) m[i] = rseed(i);
      mv = 1'b0; mwarm = 1'b1; mcnt = 0;
   endtask

   task automatic cyc(input logic sv, input logic [1:0] ch, input logic [31:0] sd,
                      input logic rdy, input string tag);
      exp_t e;
      logic stp;
      seed_valid = sv; seed_chan = ch; seed_data = sd; out_ready = rdy;
`ifdef XORSHIFT_WARMUP_EN
      stp = mwarm | (mv & rdy);
`else
      stp = mv & rdy;
`endif
      for (int i = 0; i < CH; i++) begin
         if (sv && (int'(ch) == i)) m[i] = (sd == 32'h0) ? rseed(i) : sd;
         else if (stp)              m[i] = xs(m[i]);
      end
`ifdef XORSHIFT_WARMUP_EN
      if (sv) begin
         mwarm = 1'b1; mcnt = 0;
      end else if (mwarm) begin
         if (mcnt == WU - 1) begin mwarm = 1'b0; mcnt = 0; end
         else mcnt++;
      end
      mv = !mwarm;
`else
      mv = 1'b1;
`endif
      e.v = mv; e.d = mpack();
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      chk({tag, " valid"}, (W*CH)'(out_valid), (W*CH)'(e.v));
      chk({tag, " data"}, out_data, e.d);
      seed_valid = 1'b0;
   endtask

   logic [W*CH-1:0] hold;

   initial begin
      model_reset();
      #12;
      chk("rst valid", (W*CH)'(out_valid), '0);
      chk("rst data", out_data, mpack());
      @(posedge clk); #1;
      reset_n = 1'b1;

      cyc(1'b0, 2'd0, 32'h0, 1'b1, "first");
`ifdef XORSHIFT_WARMUP_EN
      repeat (WU + 2) cyc(1'b0, 2'd0, 32'h0, 1'b1, "warm");
`endif
      cyc(1'b1, 2'd0, 32'h1, 1'b1, "seed0");
`ifndef XORSHIFT_WARMUP_EN
      chk("seq0", (W*CH)'(out_data[31:0]), (W*CH)'(32'h0000_0001));
`endif
      cyc(1'b0, 2'd0, 32'h0, 1'b1, "step1");
`ifndef XORSHIFT_WARMUP_EN
      chk("seq1", (W*CH)'(out_data[31:0]), (W*CH)'(32'h0004_2021));
`endif
      cyc(1'b0, 2'd0, 32'h0, 1'b1, "step2");
`ifndef XORSHIFT_WARMUP_EN
      chk("seq2", (W*CH)'(out_data[31:0]), (W*CH)'(32'h0408_0601));
`endif

      cyc(1'b1, 2'd2, 32'h0, 1'b0, "zseed");
      chk("zseed ch2", (W*CH)'(out_data[95:64]), (W*CH)'(32'h6283_AD9F));
`ifdef XORSHIFT_WARMUP_EN
      repeat (WU + 1) cyc(1'b0, 2'd0, 32'h0, 1'b0, "warm2");
`endif
      cyc(1'b0, 2'd0, 32'h0, 1'b1, "zfire");
      chk("zfire nonzero", (W*CH)'(out_data[95:64] != 32'h0), (W*CH)'(1'b1));

      hold = out_data;
      repeat (10) cyc(1'b0, 2'd0, 32'h0, 1'b0, "stall");
      chk("stall hold", out_data, hold);
      cyc(1'b0, 2'd0, 32'h0, 1'b1, "onefire");
      chk("onefire step", out_data, {xs(hold[127:96]), xs(hold[95:64]), xs(hold[63:32]), xs(hold[31:0])});

      hold = out_data;
      cyc(1'b1, 2'd1, 32'hDEAD_BEEF, 1'b1, "seedfire");
`ifndef XORSHIFT_WARMUP_EN
      chk("seedfire", out_data, {xs(hold[127:96]), xs(hold[95:64]), 32'hDEAD_BEEF, xs(hold[31:0])});
`endif

      repeat (40)
         cyc(($urandom_range(0, 7) == 0), 2'($urandom),
             ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom),
             1'($urandom_range(0, 1)), "rand");
`ifdef XORSHIFT_WARMUP_EN
      repeat (WU + 4) cyc(1'b0, 2'd0, 32'h0, 1'b1, "run");
`endif

      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      chk("midrst valid", (W*CH)'(out_valid), '0);
      chk("midrst data", out_data, mpack());
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (4) cyc(1'b0, 2'd0, 32'h0, 1'b1, "post");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/xorshift_prng_bank.md
# xorshift_prng_bank

Parametrised multi-channel xorshift pseudo-random generator with seed loading and a valid/ready output stream. It supersedes the single-channel 32-bit free-running generator. It feeds randomness to measurement-sampling and noise-injection logic in the quantum-emulation datapath. Each channel holds an independent state word, and all channels advance together only when the consumer accepts a word.

## Interface
- `WIDTH`, 32, state/output word width per channel; legal values are 32 and 64 only.
- `CHANNELS`, 4, number of independent generators; legal range 1..8.
- `DEFAULT_SEED`, 64'h1A2B3C4D_5EED5EED, base seed; the low `WIDTH` bits are used.
- `WARMUP`, 16, discarded steps after reset or seed load; legal range 1..255; used only with `XORSHIFT_WARMUP_EN`.
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous assert, active-low reset.
- `seed_valid`  in  1  one-cycle seed load strobe.
- `seed_chan`  in  $clog2(CHANNELS) (min 1)  target channel of the seed.
- `seed_data`  in  WIDTH  seed value.
- `out_valid`  out  1  the word on `out_data` is valid.
- `out_ready`  in  1  consumer accepts the word.
- `out_data`  out  WIDTH*CHANNELS  channel i occupies bits [i*WIDTH +: WIDTH].

## Operation
- Step function, fully composed within one cycle on the intermediate values:
  - a = s ^ (s << A)
  - b = a ^ (b-input a >> B)
  - s' = b ^ (b << C)
- Shift constants: WIDTH=32 uses (A,B,C) = (13,17,5); WIDTH=64 uses (13,7,17). All arithmetic is truncated to `WIDTH`.
- `out_data` is the current state of each channel, taken straight from the state registers with no added latency.
- Fire = `out_valid & out_ready`. On fire, every channel steps once. With no fire, state holds.
- Seed load on `seed_valid`: the state of channel `seed_chan` is set to `seed_data`.
  - A zero seed is replaced by the channel default, so state is never 0.
  - Other channels step normally if fire occurs in the same cycle.
  - If seed and fire coincide on the same channel, the seed wins and that channel does not step.
  - A `seed_chan` value ≥ `CHANNELS` is ignored.
- Reset state of channel i: low `WIDTH` bits of `DEFAULT_SEED` ^ (i × 32'h9E3779B9, zero-extended). If that value is 0, 32'h1 is used instead.
- FSM states:
  - WARM: all channels step every cycle; `out_valid` = 0; an 8-bit counter counts up to `WARMUP`.
  - RUN: stepping is driven by the handshake.
- Stream rule: `out_data` is stable while `out_valid & !out_ready`. The only exception is the seeded channel during a seed load.

## Timing
- During reset: `out_valid` = 0, all states at their reset seeds, FSM in WARM (macro on) or RUN (macro off), warm-up counter = 0.
- `out_valid` is registered. Without warm-up it rises on the first rising edge after `reset_n` deasserts.
- Generation latency is 0: the stepped word is visible the cycle after fire.
- Seed latency: the seeded value appears on `out_data` one cycle after `seed_valid`.
- `reset_n` asserted mid-operation: all state is reset immediately and asynchronously. Any pending word is lost.

## Configuration
- `XORSHIFT_WARMUP_EN` defined:
  - Reset enters WARM for exactly `WARMUP` cycles, then moves to RUN.
  - A seed load in any state returns the FSM to WARM. `out_valid` drops on the next edge and the counter restarts.
  - A seed during WARM restarts the count.
- `XORSHIFT_WARMUP_EN` not defined:
  - There is no WARM state and no counter.
  - `out_valid` stays high from the first post-reset edge onward.
  - Seed loads never deassert `out_valid`.

## Structure
- Shared package `prng_pkg`:
  - shift-constant triples for 32 and 64 bits
  - golden-ratio channel offset 32'h9E3779B9
  - zero-seed fallback constant
- Sub-module `xorshift_step`: purely combinational, parameter `WIDTH`, computes s → s'. It is instantiated once per channel.
- Top level holds the state registers, seed mux, FSM, warm-up counter and handshake logic.

## Test plan
- WIDTH=32, CHANNELS=1, macro off, seed ch0 = 1, `out_ready` = 1 → successive words 0x00000001, 0x00042021, 0x04080601.
- Zero seed to ch2 → `out_data[95:64]` equals the ch2 reset seed, and the next fire does not produce 0.
- Macro on, WARMUP=16 → `out_valid` is low for exactly 16 cycles after reset. The first valid word equals the reset seed stepped 16 times in the reference model.
- `out_ready` = 0 for 10 cycles → `out_data` is unchanged. Then a single fire → exactly one step on all channels.
- Simultaneous `seed_valid` (ch1 = 0xDEADBEEF) and fire → ch1 = 0xDEADBEEF and ch0, ch2, ch3 each step once.
- `reset_n` pulsed low mid-stream → `out_valid` = 0 immediately, and the state returns to the reset seeds asynchronously.
